alu_mul_seq: RTL and testbench

Multi-cycle shift-and-add multiplier controller that sequences the shared 16-bit ALU to compute the low 16 bits of an unsigned 16x16 product. It sits beside the ALU in the execute stage. While busy it drives the ALU operand and opcode inputs through the top-level ALU input mux, selected by `alu_sel`. It consumes the ALU result combinationally in the same cycle. It never modifies the ALU itself; it only issues add, shift-left-logical and shift-right-logical operations.

---
 rtl/alu_mul_seq.sv | 150 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//   Shift-and-add multiplier controller. It borrows the shared 16-bit ALU
//   through the top-level operand mux and computes the low 16 bits of an
//   unsigned 16x16 product. The design issues only add, logical shift left
//   and logical shift right operations. The ALU result comes back
//   combinationally in the same cycle.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   multiply request, accepted only while idle
//   a, b     in   multiplicand / multiplier, sampled on the accept cycle
//   alu_out  in   shared ALU result (combinational return path)
//   alu_sel  out  1 = controller owns the ALU this cycle
//   alu_ina  out  ALU operand A
//   alu_inb  out  ALU operand B
//   alu_op   out  ALU opcode
//   busy     out  high from the cycle after accept through the DONE cycle
//   done     out  single-cycle completion pulse
//   result   out  product mod 2^16, held until the next accept
// ---------------------------------------------------------------------------
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SLL = 4'b0101,
  parameter logic [3:0] OP_SRL = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] alu_out,
  output logic        alu_sel,
  output logic [15:0] alu_ina,
  output logic [15:0] alu_inb,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHM  = 3'd2,
    S_SHQ  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_m;     // multiplicand, moves left one bit per iteration
  logic [15:0] r_q;     // multiplier, moves right one bit per iteration
  logic [15:0] r_p;     // accumulator
  logic        r_busy;
  logic        r_done;

  // busy and done are registered alongside the state so that they change
  // exactly on the edge that enters or leaves the relevant states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= 16'h0000;
      r_q     <= 16'h0000;
      r_p     <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_p     <= 16'h0000;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          // An empty multiplier means no partial products remain.
          if (r_q == 16'h0000) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (r_q[0]) begin
              r_p <= alu_out;
            end
            r_state <= S_SHM;
          end
        end
        S_SHM: begin
          r_m     <= alu_out;
          r_state <= S_SHQ;
        end
        S_SHQ: begin
          r_q     <= alu_out;
          r_state <= S_ADD;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU request decode. It depends only on registered state. While the
  // controller does not own the ALU, every request output is held at zero.
  // The add is issued even when Q[0]=0 so the bus pattern is uniform.
  // In that case the result is simply not captured.
  always_comb begin
    alu_sel = 1'b0;
    alu_op  = 4'b0000;
    alu_ina = 16'h0000;
    alu_inb = 16'h0000;
    case (r_state)
      S_ADD: begin
        if (r_q != 16'h0000) begin
          alu_sel = 1'b1;
          alu_op  = OP_ADD;
          alu_ina = r_p;
          alu_inb = r_m;
        end
      end
      S_SHM: begin
        alu_sel = 1'b1;
        alu_op  = OP_SLL;
        alu_ina = r_m;
        alu_inb = 16'h0001;
      end
      S_SHQ: begin
        alu_sel = 1'b1;
        alu_op  = OP_SRL;
        alu_ina = r_q;
        alu_inb = 16'h0001;
      end
      default: ;
    endcase
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_p;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] alu_out;
  logic        alu_sel;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic [3:0]  alu_op;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle history of the ALU request, indexed by cycle after accept.
  logic [3:0] op_hist  [0:63];
  logic       sel_hist [0:63];

  alu_mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .alu_out (alu_out),
    .alu_sel (alu_sel),
    .alu_ina (alu_ina),
    .alu_inb (alu_inb),
    .alu_op  (alu_op),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the shared ALU that sits outside the controller.
  always_comb begin
    case (alu_op)
      4'b0001: alu_out = alu_ina + alu_inb;
      4'b0101: alu_out = alu_ina << alu_inb[3:0];
      4'b0111: alu_out = alu_ina >> alu_inb[3:0];
      default: alu_out = 16'h0000;
    endcase
  end

  // Reference model: the product and the completion cycle, derived from
  // arithmetic alone.
  function automatic logic [15:0] ref_product(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] full;
    full = 32'(x) * 32'(y);
    return full[15:0];
  endfunction

  function automatic int ref_top_bit(input logic [15:0] y);
    int k;
    k = -1;
    for (int i = 0; i < 16; i++) if (y[i]) k = i;
    return k;
  endfunction

  function automatic int ref_done_cycle(input logic [15:0] y);
    int k;
    k = ref_top_bit(y);
    return (k < 0) ? 2 : 3 * k + 5;
  endfunction

  // The caller must be positioned just after a falling edge. This task
  // drives the accept in the current cycle and then samples every falling
  // edge. It returns at the cycle after DONE, which is the earliest slot
  // for the next accept. start is pulsed with a=7, b=7 in cycles c1 and c2.
  task automatic run_mul(input logic [15:0] ia, input logic [15:0] ib,
                         input int c1, input int c2,
                         output int first_done, output int n_done,
                         output logic [15:0] res_done, output logic [15:0] res_after,
                         output logic busy_after);
    first_done = -1;
    n_done     = 0;
    res_done   = 16'hxxxx;
    res_after  = 16'hxxxx;
    busy_after = 1'bx;
    for (int i = 0; i < 64; i++) begin
      op_hist[i]  = 4'h0;
      sel_hist[i] = 1'b0;
    end
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      op_hist[cyc]  = alu_op;
      sel_hist[cyc] = alu_sel;
      if (first_done >= 0 && cyc == first_done + 1) begin
        busy_after = busy;
        res_after  = result;
        if (done) n_done++;
        break;
      end
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = cyc;
          res_done   = result;
        end
      end
      if (cyc == c1 || cyc == c2) begin
        start = 1'b1;
        a     = 16'h0007;
        b     = 16'h0007;
      end else begin
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done, alu_sel, result, alu_op, alu_ina, alu_inb} !== {3'b000, 16'h0, 4'h0, 16'h0, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got busy=%b done=%b sel=%b result=%h op=%h ina=%h inb=%h required all zero",
                 i, busy, done, alu_sel, result, alu_op, alu_ina, alu_inb);
      end
    end
    $display("[TB] reset: 10 idle cycles observed");
  endtask

  // Shared expectation block for a single multiply.
  task automatic check_mul(input string name, input logic [15:0] ia, input logic [15:0] ib);
    int fd, nd, exp_fd, k;
    logic [15:0] rd, ra, exp_r;
    logic ba;
    logic [3:0] exp_op;
    run_mul(ia, ib, -1, -1, fd, nd, rd, ra, ba);
    exp_fd = ref_done_cycle(ib);
    exp_r  = ref_product(ia, ib);
    k      = ref_top_bit(ib);
    $display("[TB] %s a=%h b=%h -> done_cycle=%0d result=%h (ref %0d / %h)", name, ia, ib, fd, rd, exp_fd, exp_r);
    n_tests++;
    if (fd !== exp_fd) begin
      n_fail++;
      $display("FAIL %s_latency got done cycle %0d required %0d", name, fd, exp_fd);
    end
    n_tests++;
    if (rd !== exp_r) begin
      n_fail++;
      $display("FAIL %s_result got %h required %h", name, rd, exp_r);
    end
    n_tests++;
    if (nd !== 1 || ba !== 1'b0 || ra !== exp_r) begin
      n_fail++;
      $display("FAIL %s_after got ndone=%0d busy=%b result=%h required 1 0 %h", name, nd, ba, ra, exp_r);
    end
    for (int c = 1; c <= 3 * k + 3; c++) begin
      case ((c - 1) % 3)
        0:       exp_op = 4'b0001;
        1:       exp_op = 4'b0101;
        default: exp_op = 4'b0111;
      endcase
      n_tests++;
      if (sel_hist[c] !== 1'b1 || op_hist[c] !== exp_op) begin
        n_fail++;
        $display("FAIL %s_opseq cyc=%0d got sel=%b op=%b required 1 %b", name, c, sel_hist[c], op_hist[c], exp_op);
      end
    end
  endtask

  task automatic test_basic;
    check_mul("basic", 16'h0003, 16'h0005);
  endtask

  task automatic test_zero;
    check_mul("zero", 16'h1234, 16'h0000);
    n_tests++;
    if (sel_hist[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_no_alu got sel=%b in ADD required 0", sel_hist[1]);
    end
  endtask

  task automatic test_wrap;
    check_mul("wrap_max", 16'hFFFF, 16'hFFFF);
    check_mul("wrap_pow", 16'h0100, 16'h0100);
  endtask

  task automatic test_ignored_start;
    int fd, nd;
    logic [15:0] rd, ra;
    logic ba;
    run_mul(16'h0003, 16'h0005, 4, 11, fd, nd, rd, ra, ba);
    $display("[TB] ignored_start done_cycle=%0d ndone=%0d result=%h busy12=%b", fd, nd, rd, ba);
    n_tests++;
    if (fd !== 11 || nd !== 1) begin
      n_fail++;
      $display("FAIL ignored_start_done got cycle %0d count %0d required 11 1", fd, nd);
    end
    n_tests++;
    if (rd !== 16'h000F || ra !== 16'h000F) begin
      n_fail++;
      $display("FAIL ignored_start_result got %h/%h required 000f", rd, ra);
    end
    n_tests++;
    if (ba !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_idle got busy=%b in cycle 12 required 0", ba);
    end
    // Confirm the cycle-11 start did not get queued.
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_noqueue got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int fd, nd, seen_done;
    logic [15:0] rd, ra;
    logic ba;
    seen_done = 0;
    start = 1'b1;
    a     = 16'h0003;
    b     = 16'h0005;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done++;
      if (cyc == 6) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset_mid cycle7 busy=%b done=%b result=%h", busy, done, result);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || seen_done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b done=%b result=%h early_done=%0d required 0 0 0000 0",
               busy, done, result, seen_done);
    end
    run_mul(16'h0002, 16'h0002, -1, -1, fd, nd, rd, ra, ba);
    $display("[TB] reset_mid_restart done_cycle=%0d result=%h", fd, rd);
    n_tests++;
    if (fd !== 8 || rd !== 16'h0004) begin
      n_fail++;
      $display("FAIL reset_mid_restart got cycle %0d result %h required 8 0004", fd, rd);
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    int bw;
    for (int t = 0; t < 16; t++) begin
      ra = 16'($urandom);
      bw = $urandom_range(0, 16);
      rb = (bw == 0) ? 16'h0 : 16'($urandom & ((32'd1 << bw) - 32'd1));
      check_mul("random", ra, rb);
    end
  endtask

  task automatic test_back_to_back;
    // Each call returns in the cycle after DONE and the next call accepts
    // right away in that cycle.
    check_mul("b2b_0", 16'h00FF, 16'h0101);
    check_mul("b2b_1", 16'hABCD, 16'h0001);
    check_mul("b2b_2", 16'h8001, 16'h8000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
